frame_writer: RTL and testbench
===============================

FRAME_WRITER -- requirements
Module: frame_writer

Interface
REQ-001 The module SHALL have parameter HORIZONTAL_LENGTH, default 64, meaning pixels per panel row.
REQ-002 The module SHALL have parameter VERTICAL_LENGTH, default 32, meaning rows per half-panel; the full frame is 2*VERTICAL_LENGTH rows.
REQ-003 The module SHALL have parameter ADDR_WIDTH, default 11, meaning half-panel RAM address width: log2(HORIZONTAL_LENGTH*VERTICAL_LENGTH).
REQ-004 The module SHALL use one clock and an asynchronous, active-low reset; the ports are:
 i_clk  in  1  sole clock, rising edge
 i_reset  in  1  asynchronous active-low reset
 i_pixel  in  24  pixel {R[7:0],G[7:0],B[7:0]}
 i_valid  in  1  i_pixel valid
 i_sof  in  1  qualifies i_pixel as first pixel of a frame (meaningful only with i_valid)
 o_ready  out  1  pixel accepted when i_valid && o_ready
 i_frame_done  in  1  one-cycle pulse from display side at end of a full refresh
 o_wr_addr  out  ADDR_WIDTH  RAM write address
 o_wr_data  out  24  RAM write data
 o_we0  out  1  write enable, upper-half RAM (display data0)
 o_we1  out  1  write enable, lower-half RAM (display data1)
 o_wr_bank  out  1  bank being written
 o_disp_bank  out  1  bank display reads; always ~o_wr_bank
 o_resync  out  1  one-cycle pulse: frame restarted by mid-frame i_sof

Function
REQ-005 FSM states SHALL be IDLE, WRITE, WAIT_SWAP.
REQ-006 IDLE: o_ready=1; a handshake with i_sof=0 SHALL be discarded (no write); a handshake with i_sof=1 SHALL be written as pixel (row 0, col 0) and move to WRITE.
REQ-007 WRITE: o_ready=1; each handshake SHALL write one pixel and advance col; col wraps HORIZONTAL_LENGTH-1 -> 0 with row+1.
REQ-008 Accepting pixel (row 2*VERTICAL_LENGTH-1, col HORIZONTAL_LENGTH-1) SHALL move WRITE -> WAIT_SWAP.
REQ-009 WAIT_SWAP: o_ready=0; i_frame_done=1 SHALL toggle o_wr_bank and o_disp_bank on the next edge and return to IDLE.
REQ-010 i_frame_done SHALL be ignored outside WAIT_SWAP, including the cycle the last pixel is accepted.
REQ-011 Mapping: row < VERTICAL_LENGTH -> o_we0; otherwise -> o_we1; o_wr_addr = (row mod VERTICAL_LENGTH)*HORIZONTAL_LENGTH + col.
REQ-012 Write latency SHALL be exactly 1 cycle: o_we*, o_wr_addr, o_wr_data registered from the handshake cycle; o_we0/o_we1 never both 1; both 0 in cycles without a handshake.
REQ-013 Handshake in WRITE with i_sof=1 SHALL write that pixel at (0,0), set counters to (0,1), and pulse o_resync for one cycle; bank unchanged.
REQ-014 Back-to-back handshakes SHALL sustain one pixel per cycle; gaps in i_valid SHALL not alter counters.
REQ-015 Counters SHALL be sized to hold 2*VERTICAL_LENGTH-1 and HORIZONTAL_LENGTH-1 without overflow; no wrap beyond the frame.

Reset
REQ-016 While i_reset=0: state IDLE, row=col=0, o_ready=0, o_we0=o_we1=0, o_wr_addr=0, o_wr_data=0, o_wr_bank=1, o_disp_bank=0, o_resync=0.
REQ-017 o_ready SHALL rise on the first edge after reset release.
REQ-018 Reset mid-frame SHALL abandon the partial frame; no further writes until a new i_sof.

Verification
REQ-019 Full frame: i_sof + 4096 consecutive pixels (value = index) -> 2048 o_we0 writes addr 0..2047, then 2048 o_we1 writes addr 0..2047, data matching, each 1 cycle after handshake; then o_ready=0.
REQ-020 Swap: in WAIT_SWAP pulse i_frame_done -> next cycle o_disp_bank=1, o_wr_bank=0, state IDLE, o_ready=1.
REQ-021 Pre-sync: 10 pixels with i_sof=0 after reset, then i_sof pixel -> only the i_sof pixel written, addr 0, o_we0.
REQ-022 Resync: i_sof at pixel index 100 -> o_resync pulse, that pixel written addr 0 o_we0, next pixel addr 1.
REQ-023 Boundary/ignore: i_frame_done pulsed on last-pixel handshake -> no swap; second pulse in WAIT_SWAP -> swap; random i_valid gaps give identical RAM contents to gapless case.
REQ-024 Reset at pixel 3000 (i_reset=0 two cycles) -> all outputs at REQ-016 values, banks 1/0, no write until new i_sof.

Source files
------------

// File: rtl/frame_writer.sv
// ---------------------------------------------------------------------------
// frame_writer
//
// Accepts a raster stream of 24-bit pixels and writes them into a pair of
// half-panel RAMs: rows 0..VERTICAL_LENGTH-1 go to the upper RAM (o_we0) and
// rows VERTICAL_LENGTH..2*VERTICAL_LENGTH-1 go to the lower RAM (o_we1).
// Both RAMs are double-buffered. o_wr_bank selects the bank being filled, and
// o_disp_bank selects the bank the display side reads. Once a whole frame has
// been written, the writer stalls until the display reports the end of a
// refresh. It then swaps the banks.
//
// Ports
//   i_clk         sole clock, rising edge
//   i_reset       asynchronous active-low reset
//   i_pixel       pixel {R[7:0],G[7:0],B[7:0]}
//   i_valid       i_pixel valid
//   i_sof         marks i_pixel as the first pixel of a frame
//   o_ready       pixel accepted when i_valid && o_ready
//   i_frame_done  one-cycle pulse from the display at the end of a refresh
//   o_wr_addr     RAM write address ((row mod VERTICAL_LENGTH)*H + col)
//   o_wr_data     RAM write data
//   o_we0         write enable, upper-half RAM
//   o_we1         write enable, lower-half RAM
//   o_wr_bank     bank being written
//   o_disp_bank   bank being displayed (always the other bank)
//   o_resync      one-cycle pulse when a mid-frame i_sof restarts the frame
// ---------------------------------------------------------------------------
module frame_writer #(
    parameter int HORIZONTAL_LENGTH = 64,
    parameter int VERTICAL_LENGTH   = 32,
    parameter int ADDR_WIDTH        = 11
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [23:0]           i_pixel,
    input  logic                  i_valid,
    input  logic                  i_sof,
    output logic                  o_ready,
    input  logic                  i_frame_done,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [23:0]           o_wr_data,
    output logic                  o_we0,
    output logic                  o_we1,
    output logic                  o_wr_bank,
    output logic                  o_disp_bank,
    output logic                  o_resync
);

    localparam int ROWS  = 2 * VERTICAL_LENGTH;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (HORIZONTAL_LENGTH > 1) ? $clog2(HORIZONTAL_LENGTH) : 1;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] HALF_ROW = ROW_W'(VERTICAL_LENGTH);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(HORIZONTAL_LENGTH - 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WRITE     = 2'd1;
    localparam logic [1:0] S_WAIT_SWAP = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic                  ready_q, ready_d;
    logic                  we0_q, we0_d;
    logic                  we1_q, we1_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [23:0]           wr_data_q, wr_data_d;
    logic                  wr_bank_q, wr_bank_d;
    logic                  resync_q, resync_d;

    logic                  handshake;
    logic                  write_en;
    logic [ROW_W-1:0]      pix_row;
    logic [COL_W-1:0]      pix_col;
    logic                  lower_half;
    logic [ROW_W-1:0]      half_row;

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        we0_d     = 1'b0;
        we1_d     = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_bank_d = wr_bank_q;
        resync_d  = 1'b0;
        write_en  = 1'b0;

        handshake = i_valid && ready_q;

        // A start-of-frame pixel always lands at (0,0), whatever the counters say.
        pix_row    = i_sof ? '0 : row_q;
        pix_col    = i_sof ? '0 : col_q;
        lower_half = (pix_row >= HALF_ROW);
        half_row   = lower_half ? (pix_row - HALF_ROW) : pix_row;

        case (state_q)
            S_IDLE: begin
                // Pixels seen before the first start-of-frame are dropped.
                if (handshake && i_sof) begin
                    write_en = 1'b1;
                end
            end
            S_WRITE: begin
                if (handshake) begin
                    write_en = 1'b1;
                    resync_d = i_sof;
                end
            end
            S_WAIT_SWAP: begin
                if (i_frame_done) begin
                    wr_bank_d = ~wr_bank_q;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (write_en) begin
            we0_d     = ~lower_half;
            we1_d     = lower_half;
            wr_addr_d = ADDR_WIDTH'(half_row) * ADDR_WIDTH'(HORIZONTAL_LENGTH)
                      + ADDR_WIDTH'(pix_col);
            wr_data_d = i_pixel;
            if (pix_row == LAST_ROW && pix_col == LAST_COL) begin
                // The frame is complete. Park the counters at the origin for the next one.
                state_d = S_WAIT_SWAP;
                row_d   = '0;
                col_d   = '0;
            end else begin
                state_d = S_WRITE;
                if (pix_col == LAST_COL) begin
                    col_d = '0;
                    row_d = pix_row + ROW_W'(1);
                end else begin
                    col_d = pix_col + COL_W'(1);
                    row_d = pix_row;
                end
            end
        end

        // o_ready is registered. It follows the state being entered, so it drops
        // the cycle after the last pixel and rises the cycle after the swap.
        ready_d = (state_d != S_WAIT_SWAP);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            ready_q   <= 1'b0;
            we0_q     <= 1'b0;
            we1_q     <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_bank_q <= 1'b1;
            resync_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            ready_q   <= ready_d;
            we0_q     <= we0_d;
            we1_q     <= we1_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_bank_q <= wr_bank_d;
            resync_q  <= resync_d;
        end
    end

    assign o_ready     = ready_q;
    assign o_we0       = we0_q;
    assign o_we1       = we1_q;
    assign o_wr_addr   = wr_addr_q;
    assign o_wr_data   = wr_data_q;
    assign o_wr_bank   = wr_bank_q;
    assign o_disp_bank = ~wr_bank_q;
    assign o_resync    = resync_q;

endmodule

// File: tb/tb_frame_writer.sv
// ---------------------------------------------------------------------------
// tb_frame_writer
//
// Directed testbench for frame_writer with the default 64x(2*32) geometry.
// It starts with a table of single-cycle vectors covering pre-sync dropping,
// the first write, a resync, and i_frame_done ignored in WRITE. Hand-written
// sequences then cover the following:
//   - a full gapless frame
//   - the bank swap
//   - a frame with random i_valid gaps, compared with the gapless RAM image
//   - a resync at pixel 100
//   - a reset at pixel 3000
// ---------------------------------------------------------------------------
module tb_frame_writer;

    localparam int H     = 64;
    localparam int V     = 32;
    localparam int AW    = 11;
    localparam int HALF  = H * V;
    localparam int FRAME = 2 * H * V;

    logic          i_clk;
    logic          i_reset;
    logic [23:0]   i_pixel;
    logic          i_valid;
    logic          i_sof;
    logic          o_ready;
    logic          i_frame_done;
    logic [AW-1:0] o_wr_addr;
    logic [23:0]   o_wr_data;
    logic          o_we0;
    logic          o_we1;
    logic          o_wr_bank;
    logic          o_disp_bank;
    logic          o_resync;

    frame_writer #(
        .HORIZONTAL_LENGTH (H),
        .VERTICAL_LENGTH   (V),
        .ADDR_WIDTH        (AW)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_pixel      (i_pixel),
        .i_valid      (i_valid),
        .i_sof        (i_sof),
        .o_ready      (o_ready),
        .i_frame_done (i_frame_done),
        .o_wr_addr    (o_wr_addr),
        .o_wr_data    (o_wr_data),
        .o_we0        (o_we0),
        .o_we1        (o_we1),
        .o_wr_bank    (o_wr_bank),
        .o_disp_bank  (o_disp_bank),
        .o_resync     (o_resync)
    );

    typedef struct {
        logic        valid;
        logic        sof;
        logic        fd;
        logic [23:0] pixel;
        logic        exp_ready;
        logic        exp_we0;
        logic        exp_we1;
        logic        chk_wr;
        logic [AW-1:0] exp_addr;
        logic [23:0] exp_data;
        logic        exp_resync;
    } vec_t;

    int   checks;
    int   errors;
    int   pos;
    logic synced;

    logic [23:0] ram0 [HALF];
    logic [23:0] ram1 [HALF];
    logic [23:0] ref0 [HALF];
    logic [23:0] ref1 [HALF];

    // Free-running clock
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Watchdog so the run always terminates
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic sof,
                                 input logic [23:0] pixel, input logic fd);
        i_valid      = valid;
        i_sof        = sof;
        i_pixel      = pixel;
        i_frame_done = fd;
    endtask

    // Advance one clock. Then mirror any RAM write into the bench's RAM image.
    task automatic step();
        @(posedge i_clk);
        #1;
        if (o_we0 === 1'b1) ram0[o_wr_addr] = o_wr_data;
        if (o_we1 === 1'b1) ram1[o_wr_addr] = o_wr_data;
    endtask

    task automatic clearRam();
        for (int a = 0; a < HALF; a++) begin
            ram0[a] = 24'hFFFFFF;
            ram1[a] = 24'hFFFFFF;
        end
    endtask

    // Drive one handshake. Then check the write against the bench's own position model.
    task automatic sendPixel(input logic [23:0] data, input logic sof, input logic fd);
        logic exp_wr;
        logic exp_res;
        int   row;
        int   col;
        checkOutput("ready_before_hs", 32'(o_ready), 32'd1);
        exp_wr  = sof || synced;
        exp_res = sof && synced;
        if (sof) pos = 0;
        row = pos / H;
        col = pos % H;
        applyStimulus(1'b1, sof, data, fd);
        step();
        applyStimulus(1'b0, 1'b0, 24'h0, 1'b0);
        if (exp_wr) begin
            checkOutput($sformatf("px%0d_we0", pos), 32'(o_we0), 32'(row < V));
            checkOutput($sformatf("px%0d_we1", pos), 32'(o_we1), 32'(row >= V));
            checkOutput($sformatf("px%0d_addr", pos), 32'(o_wr_addr), 32'((row % V) * H + col));
            checkOutput($sformatf("px%0d_data", pos), 32'(o_wr_data), 32'(data));
            checkOutput($sformatf("px%0d_resync", pos), 32'(o_resync), 32'(exp_res));
            pos++;
            synced = 1'b1;
            if (pos == FRAME) begin
                synced = 1'b0;
                pos    = 0;
            end
        end else begin
            checkOutput("drop_we0", 32'(o_we0), 32'd0);
            checkOutput("drop_we1", 32'(o_we1), 32'd0);
        end
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 24'h0, 1'b0);
        step();
        checkOutput("gap_we0", 32'(o_we0), 32'd0);
        checkOutput("gap_we1", 32'(o_we1), 32'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ready"}, 32'(o_ready), 32'd0);
        checkOutput({tag, "_we0"}, 32'(o_we0), 32'd0);
        checkOutput({tag, "_we1"}, 32'(o_we1), 32'd0);
        checkOutput({tag, "_addr"}, 32'(o_wr_addr), 32'd0);
        checkOutput({tag, "_data"}, 32'(o_wr_data), 32'd0);
        checkOutput({tag, "_wr_bank"}, 32'(o_wr_bank), 32'd1);
        checkOutput({tag, "_disp_bank"}, 32'(o_disp_bank), 32'd0);
        checkOutput({tag, "_resync"}, 32'(o_resync), 32'd0);
    endtask

    task automatic doReset(input string tag);
        i_reset = 1'b0;
        #1;
        checkResetValues({tag, "_async"});
        step();
        step();
        checkResetValues({tag, "_held"});
        applyStimulus(1'b0, 1'b0, 24'h0, 1'b0);
        i_reset = 1'b1;
        #1;
        checkOutput({tag, "_ready_before_edge"}, 32'(o_ready), 32'd0);
        step();
        checkOutput({tag, "_ready_after_edge"}, 32'(o_ready), 32'd1);
        synced = 1'b0;
        pos    = 0;
    endtask

    function automatic vec_t mkVec(input logic valid, input logic sof, input logic fd,
                                   input logic [23:0] pixel, input logic we0,
                                   input logic [AW-1:0] addr, input logic resync);
        vec_t v;
        v.valid      = valid;
        v.sof        = sof;
        v.fd         = fd;
        v.pixel      = pixel;
        v.exp_ready  = 1'b1;
        v.exp_we0    = we0;
        v.exp_we1    = 1'b0;
        v.chk_wr     = we0;
        v.exp_addr   = addr;
        v.exp_data   = pixel;
        v.exp_resync = resync;
        return v;
    endfunction

    initial begin
        vec_t vecs [18];
        int   mism;
        int   mism_ref;

        checks = 0;
        errors = 0;
        synced = 1'b0;
        pos    = 0;
        i_reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 24'h0, 1'b0);
        clearRam();

        // The vector table covers ten pre-sync pixels, the sync pixel, a gap,
        // a resync, and i_frame_done pulsed during WRITE.
        for (int i = 0; i < 10; i++) begin
            vecs[i] = mkVec(1'b1, 1'b0, 1'b0, 24'hA0 + 24'(i), 1'b0, '0, 1'b0);
        end
        vecs[10] = mkVec(1'b1, 1'b1, 1'b0, 24'h111111, 1'b1, 11'd0, 1'b0);
        vecs[11] = mkVec(1'b0, 1'b0, 1'b0, 24'h0,      1'b0, 11'd0, 1'b0);
        vecs[12] = mkVec(1'b1, 1'b0, 1'b0, 24'h222222, 1'b1, 11'd1, 1'b0);
        vecs[13] = mkVec(1'b1, 1'b0, 1'b0, 24'h333333, 1'b1, 11'd2, 1'b0);
        vecs[14] = mkVec(1'b1, 1'b1, 1'b0, 24'h444444, 1'b1, 11'd0, 1'b1);
        vecs[15] = mkVec(1'b1, 1'b0, 1'b0, 24'h555555, 1'b1, 11'd1, 1'b0);
        vecs[16] = mkVec(1'b0, 1'b0, 1'b1, 24'h0,      1'b0, 11'd0, 1'b0);
        vecs[17] = mkVec(1'b1, 1'b0, 1'b0, 24'h666666, 1'b1, 11'd2, 1'b0);

        $display("[TB] reset and vector table");
        repeat (2) @(posedge i_clk);
        doReset("rst0");

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].sof, vecs[i].pixel, vecs[i].fd);
            step();
            checkOutput($sformatf("vec%0d_we0", i), 32'(o_we0), 32'(vecs[i].exp_we0));
            checkOutput($sformatf("vec%0d_we1", i), 32'(o_we1), 32'(vecs[i].exp_we1));
            checkOutput($sformatf("vec%0d_resync", i), 32'(o_resync), 32'(vecs[i].exp_resync));
            checkOutput($sformatf("vec%0d_ready", i), 32'(o_ready), 32'(vecs[i].exp_ready));
            checkOutput($sformatf("vec%0d_wr_bank", i), 32'(o_wr_bank), 32'd1);
            if (vecs[i].chk_wr) begin
                checkOutput($sformatf("vec%0d_addr", i), 32'(o_wr_addr), 32'(vecs[i].exp_addr));
                checkOutput($sformatf("vec%0d_data", i), 32'(o_wr_data), 32'(vecs[i].exp_data));
            end
        end
        applyStimulus(1'b0, 1'b0, 24'h0, 1'b0);

        // Run a full gapless frame, pulsing i_frame_done on the last handshake.
        $display("[TB] full gapless frame");
        doReset("rst1");
        clearRam();
        for (int i = 0; i < FRAME; i++) begin
            sendPixel(24'(i), (i == 0), (i == FRAME - 1));
        end
        mism = 0;
        for (int a = 0; a < HALF; a++) begin
            if (ram0[a] !== 24'(a)) mism++;
            if (ram1[a] !== 24'(HALF + a)) mism++;
            ref0[a] = ram0[a];
            ref1[a] = ram1[a];
        end
        checkOutput("gapless_ram_image", 32'(mism), 32'd0);

        // In WAIT_SWAP, ready is low, the early frame_done has been ignored,
        // and valid does not cause a write.
        checkOutput("wait_ready", 32'(o_ready), 32'd0);
        checkOutput("wait_no_swap_wr", 32'(o_wr_bank), 32'd1);
        checkOutput("wait_no_swap_disp", 32'(o_disp_bank), 32'd0);
        applyStimulus(1'b1, 1'b0, 24'h123456, 1'b0);
        step();
        checkOutput("wait_valid_we0", 32'(o_we0), 32'd0);
        checkOutput("wait_valid_we1", 32'(o_we1), 32'd0);
        checkOutput("wait_hold_ready", 32'(o_ready), 32'd0);
        checkOutput("wait_hold_bank", 32'(o_wr_bank), 32'd1);
        applyStimulus(1'b0, 1'b0, 24'h0, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0, 24'h0, 1'b0);
        checkOutput("swap_disp_bank", 32'(o_disp_bank), 32'd1);
        checkOutput("swap_wr_bank", 32'(o_wr_bank), 32'd0);
        checkOutput("swap_ready", 32'(o_ready), 32'd1);
        // Back in IDLE, a non-sof pixel is dropped.
        sendPixel(24'h0BAD00, 1'b0, 1'b0);

        // Run a frame with random i_valid gaps. Its RAM image must match the gapless run.
        $display("[TB] frame with random gaps");
        clearRam();
        for (int i = 0; i < FRAME; i++) begin
            if (i != 0 && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) idleCycle();
            end
            sendPixel(24'(i), (i == 0), 1'b0);
        end
        mism_ref = 0;
        for (int a = 0; a < HALF; a++) begin
            if (ram0[a] !== ref0[a]) mism_ref++;
            if (ram1[a] !== ref1[a]) mism_ref++;
        end
        checkOutput("gap_ram_vs_gapless", 32'(mism_ref), 32'd0);
        checkOutput("gap_wait_ready", 32'(o_ready), 32'd0);
        applyStimulus(1'b0, 1'b0, 24'h0, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0, 24'h0, 1'b0);
        checkOutput("swap2_wr_bank", 32'(o_wr_bank), 32'd1);
        checkOutput("swap2_disp_bank", 32'(o_disp_bank), 32'd0);

        // Resync at pixel 100. The frame then continues to pixel 3000, and reset hits mid-frame.
        $display("[TB] resync and mid-frame reset");
        for (int i = 0; i < 100; i++) begin
            sendPixel(24'h100000 + 24'(i), (i == 0), 1'b0);
        end
        sendPixel(24'h200064, 1'b1, 1'b0);
        checkOutput("resync_pulse", 32'(o_resync), 32'd1);
        checkOutput("resync_addr", 32'(o_wr_addr), 32'd0);
        checkOutput("resync_we0", 32'(o_we0), 32'd1);
        sendPixel(24'h200065, 1'b0, 1'b0);
        checkOutput("after_resync_addr", 32'(o_wr_addr), 32'd1);
        checkOutput("after_resync_pulse", 32'(o_resync), 32'd0);
        while (pos < 3000) begin
            sendPixel(24'h300000 + 24'(pos), 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 24'h777777, 1'b0);
        doReset("rst_mid");
        for (int i = 0; i < 5; i++) begin
            sendPixel(24'h880000 + 24'(i), 1'b0, 1'b0);
        end
        sendPixel(24'h990000, 1'b1, 1'b0);
        checkOutput("post_reset_addr", 32'(o_wr_addr), 32'd0);
        checkOutput("post_reset_we0", 32'(o_we0), 32'd1);
        checkOutput("post_reset_wr_bank", 32'(o_wr_bank), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
